// File: rtl/uart_rx_read_sequencer.sv
// APB read sequencer for the UART RX FIFO: pops one frame per read request,
// decodes data/parity/framing and answers with a single-cycle PREADY.
module uart_rx_read_sequencer #(
  parameter int FRAME_W        = 12,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               rd_req,
  input  logic [3:0]         number_data_receive,
  input  logic               parity_bit_mode,
  input  logic               stop_bit_twice,
  input  logic               fifo_not_empty,
  input  logic [FRAME_W-1:0] fifo_rd_data,
  output logic               fifo_rd_en,
  output logic               PREADY,
  output logic [DATA_W-1:0]  PRDATA,
  output logic               parity_err,
  output logic               frame_err,
  output logic               timeout_flag,
  output logic               busy,
  output logic [7:0]         frames_read
);

  localparam int IDX_W = $clog2(FRAME_W);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_POP,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_tmo_cnt;
  logic [FRAME_W-1:0] r_frame;
  logic               r_timeout;
  logic [DATA_W-1:0]  r_prdata_hold;
  logic [7:0]         r_frames_read;
  logic               w_tmo_hit;

  logic [IDX_W-1:0]   w_n;
  logic [IDX_W-1:0]   w_par_idx;
  logic [IDX_W-1:0]   w_stop1_idx;
  logic [IDX_W-1:0]   w_stop2_idx;
  logic [DATA_W-1:0]  w_data;
  logic [DATA_W-1:0]  w_resp_data;
  logic               w_parity_err;
  logic               w_frame_err;
  logic               w_in_resp;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state       <= S_IDLE;
      r_tmo_cnt     <= '0;
      r_frame       <= '0;
      r_timeout     <= 1'b0;
      r_prdata_hold <= '0;
      r_frames_read <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE) begin
        r_tmo_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      end
      if (r_state == S_POP) begin
        r_frames_read <= r_frames_read + 8'd1;
      end
      if (r_state == S_CAPTURE) begin
        r_frame <= fifo_rd_data;
      end
      // The timeout marker must survive through the response cycle.
      if (r_state != S_RESP) begin
        r_timeout <= w_tmo_hit;
      end else begin
        r_prdata_hold <= w_resp_data;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_tmo_hit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rd_req) begin
          w_next_state = fifo_not_empty ? S_POP : S_WAIT;
        end
      end
      S_WAIT: begin
        // Data arriving wins over an expiring timeout in the same cycle.
        if (fifo_not_empty) begin
          w_next_state = S_POP;
        end else if (r_tmo_cnt == CNT_LAST) begin
          w_next_state = S_RESP;
          w_tmo_hit    = 1'b1;
        end
      end
      S_POP:     w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = S_RESP;
      S_RESP:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Data width clamped to 5..8 bits.
  always_comb begin
    if (number_data_receive < 4'd5) begin
      w_n = IDX_W'(5);
    end else if (number_data_receive > 4'd8) begin
      w_n = IDX_W'(8);
    end else begin
      w_n = IDX_W'(number_data_receive);
    end
  end

  assign w_par_idx   = w_n + IDX_W'(1);
  assign w_stop1_idx = w_n + IDX_W'(1) + IDX_W'(parity_bit_mode);
  assign w_stop2_idx = w_n + IDX_W'(2) + IDX_W'(parity_bit_mode);

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
    assign w_data[gi] = (IDX_W'(gi) < w_n) ? r_frame[gi+1] : 1'b0;
  end

  assign w_parity_err = parity_bit_mode & (^w_data ^ r_frame[w_par_idx]);
  assign w_frame_err  = r_frame[0] | ~r_frame[w_stop1_idx]
                      | (stop_bit_twice & ~r_frame[w_stop2_idx]);

  assign w_in_resp   = (r_state == S_RESP);
  assign w_resp_data = r_timeout ? '0 : w_data;

  assign fifo_rd_en   = (r_state == S_POP) & ~PRESET;
  assign PREADY       = w_in_resp;
  assign PRDATA       = w_in_resp ? w_resp_data : r_prdata_hold;
  assign timeout_flag = w_in_resp & r_timeout;
  assign parity_err   = w_in_resp & ~r_timeout & w_parity_err;
  assign frame_err    = w_in_resp & ~r_timeout & w_frame_err;
  assign busy         = (r_state != S_IDLE);
  assign frames_read  = r_frames_read;

endmodule

// File: tb/tb_uart_rx_read_sequencer.sv
// Bench for uart_rx_read_sequencer: cycle-scheduled reference model with a
// per-cycle compare, plus literal checks on directed read scenarios.
module tb_uart_rx_read_sequencer;

  localparam int T = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        rd_req;
  logic [3:0]  number_data_receive;
  logic        parity_bit_mode;
  logic        stop_bit_twice;
  logic        fifo_not_empty;
  logic [11:0] fifo_rd_data;
  logic        fifo_rd_en;
  logic        PREADY;
  logic [7:0]  PRDATA;
  logic        parity_err;
  logic        frame_err;
  logic        timeout_flag;
  logic        busy;
  logic [7:0]  frames_read;

  uart_rx_read_sequencer #(
    .FRAME_W(12), .DATA_W(8), .TIMEOUT_CYCLES(T)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .rd_req(rd_req),
    .number_data_receive(number_data_receive),
    .parity_bit_mode(parity_bit_mode), .stop_bit_twice(stop_bit_twice),
    .fifo_not_empty(fifo_not_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .PREADY(PREADY), .PRDATA(PRDATA),
    .parity_err(parity_err), .frame_err(frame_err),
    .timeout_flag(timeout_flag), .busy(busy), .frames_read(frames_read)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  // Reference model: absolute cycle numbers of scheduled events.
  int       pop_at = -1, cap_at = -1, resp_at = -1, wait_from = -1;
  bit       active = 0, m_tmo = 0;
  int       m_frames = 0;
  logic [7:0] m_data = 8'h00, m_hold = 8'h00;
  logic     m_pe = 1'b0, m_fe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void decode(input logic [11:0] f, input logic [3:0] nr,
                                 input logic p, input logic two,
                                 output logic [7:0] d, output logic pe, output logic fe);
    int n;
    int ones;
    n    = (nr < 5) ? 5 : ((nr > 8) ? 8 : int'(nr));
    d    = 8'((f >> 1) & 12'((1 << n) - 1));
    ones = $countones(d) + int'(f[n+1]);
    pe   = p && (ones % 2 == 1);
    fe   = f[0] || !f[n+1+int'(p)] || (two && !f[n+2+int'(p)]);
  endfunction

  initial begin : model
    int c;
    forever begin
      @(posedge PCLK);
      c = cyc;
      if (PRESET) begin
        pop_at = -1; cap_at = -1; resp_at = -1; wait_from = -1;
        active = 0; m_tmo = 0; m_frames = 0; m_hold = 8'h00;
      end else begin
        if (!active) begin
          if (rd_req) begin
            active = 1;
            m_tmo  = 0;
            if (fifo_not_empty) begin
              pop_at = c + 1; cap_at = c + 2; resp_at = c + 3;
            end else begin
              wait_from = c + 1;
            end
          end
        end else if (wait_from >= 0 && c >= wait_from) begin
          if (fifo_not_empty) begin
            pop_at = c + 1; cap_at = c + 2; resp_at = c + 3;
            wait_from = -1;
          end else if (c - wait_from == T - 1) begin
            resp_at = c + 1; m_tmo = 1; wait_from = -1;
          end
        end
        if (c == pop_at) m_frames = (m_frames + 1) % 256;
        if (c == cap_at)
          decode(fifo_rd_data, number_data_receive, parity_bit_mode, stop_bit_twice,
                 m_data, m_pe, m_fe);
        if (c == resp_at) begin
          active = 0;
          m_hold = m_tmo ? 8'h00 : m_data;
        end
      end
      cyc = cyc + 1;
    end
  end

  initial begin : compare
    bit er;
    forever begin
      @(negedge PCLK);
      if (chk_en) begin
        er = (cyc == resp_at);
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(cyc == pop_at));
        check("PREADY", 32'(PREADY), 32'(er));
        check("busy", 32'(busy), 32'(active));
        check("frames_read", 32'(frames_read), 32'(m_frames));
        check("PRDATA", 32'(PRDATA), 32'(er ? (m_tmo ? 8'h00 : m_data) : m_hold));
        check("timeout_flag", 32'(timeout_flag), 32'(er && m_tmo));
        check("parity_err", 32'(parity_err), 32'(er && !m_tmo && m_pe));
        check("frame_err", 32'(frame_err), 32'(er && !m_tmo && m_fe));
        if (PREADY)
          $display("resp cycle %0d: PRDATA=0x%02h perr=%0b ferr=%0b tmo=%0b frames_read=%0d",
                   cyc, PRDATA, parity_err, frame_err, timeout_flag, frames_read);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  typedef struct {
    logic [3:0]  n;
    logic        p;
    logic        two;
    logic [11:0] frame;
    logic [7:0]  data;
    logic        pe;
    logic        fe;
  } vec_t;

  vec_t vecs[8] = '{
    '{4'd8,  1'b1, 1'b0, 12'h54A, 8'hA5, 1'b0, 1'b0},
    '{4'd5,  1'b0, 1'b0, 12'h066, 8'h13, 1'b0, 1'b0},
    '{4'd5,  1'b0, 1'b0, 12'h067, 8'h13, 1'b0, 1'b1},
    '{4'd8,  1'b1, 1'b0, 12'h74A, 8'hA5, 1'b1, 1'b0},
    '{4'd3,  1'b0, 1'b0, 12'h066, 8'h13, 1'b0, 1'b0},
    '{4'd8,  1'b0, 1'b1, 12'h74A, 8'hA5, 1'b0, 1'b0},
    '{4'd8,  1'b0, 1'b1, 12'h34A, 8'hA5, 1'b0, 1'b1},
    '{4'd15, 1'b0, 1'b0, 12'h3FE, 8'hFF, 1'b0, 1'b0}
  };

  initial begin : driver
    PRESET = 1'b1; rd_req = 1'b0; fifo_not_empty = 1'b0; fifo_rd_data = 12'h000;
    number_data_receive = 4'd8; parity_bit_mode = 1'b1; stop_bit_twice = 1'b0;
    tick(2);
    chk_en = 1;
    check("reset PREADY", 32'(PREADY), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frames_read", 32'(frames_read), 32'd0);
    check("reset PRDATA", 32'(PRDATA), 32'd0);
    PRESET = 1'b0;
    tick(1);

    for (int i = 0; i < 8; i++) begin
      number_data_receive = vecs[i].n;
      parity_bit_mode     = vecs[i].p;
      stop_bit_twice      = vecs[i].two;
      fifo_rd_data        = vecs[i].frame;
      fifo_not_empty      = 1'b1;
      rd_req              = 1'b1;
      tick(1);
      check("vec pop strobe", 32'(fifo_rd_en), 32'd1);
      tick(2);
      check("vec PREADY", 32'(PREADY), 32'd1);
      check("vec PRDATA", 32'(PRDATA), 32'(vecs[i].data));
      check("vec parity_err", 32'(parity_err), 32'(vecs[i].pe));
      check("vec frame_err", 32'(frame_err), 32'(vecs[i].fe));
      if (i == 0) check("first frames_read", 32'(frames_read), 32'd1);
      tick(1);
      rd_req = 1'b0;
    end
    tick(2);

    // Timeout with the FIFO held empty.
    number_data_receive = 4'd8; parity_bit_mode = 1'b1; stop_bit_twice = 1'b0;
    fifo_rd_data = 12'h54A; fifo_not_empty = 1'b0; rd_req = 1'b1;
    tick(T);
    check("tmo early PREADY", 32'(PREADY), 32'd0);
    tick(1);
    check("tmo PREADY", 32'(PREADY), 32'd1);
    check("tmo flag", 32'(timeout_flag), 32'd1);
    check("tmo PRDATA", 32'(PRDATA), 32'd0);
    tick(1);
    rd_req = 1'b0;
    tick(2);

    // FIFO fills on the last wait cycle: data beats timeout.
    rd_req = 1'b1;
    tick(T);
    fifo_not_empty = 1'b1;
    tick(1);
    check("late pop strobe", 32'(fifo_rd_en), 32'd1);
    fifo_not_empty = 1'b0;
    tick(2);
    check("late PREADY", 32'(PREADY), 32'd1);
    check("late tmo flag", 32'(timeout_flag), 32'd0);
    check("late PRDATA", 32'(PRDATA), 32'hA5);
    tick(1);
    rd_req = 1'b0;
    tick(2);

    // Reset during CAPTURE.
    fifo_not_empty = 1'b1; rd_req = 1'b1;
    tick(2);
    PRESET = 1'b1; rd_req = 1'b0;
    tick(1);
    PRESET = 1'b0;
    check("rst PREADY", 32'(PREADY), 32'd0);
    check("rst frames_read", 32'(frames_read), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    tick(4);

    // 256 back-to-back reads: counter wraps to zero.
    for (int i = 0; i < 256; i++) begin
      fifo_rd_data = 12'((i * 173 + 5) & 12'hFFF);
      rd_req = 1'b1;
      tick(4);
    end
    rd_req = 1'b0;
    check("wrap frames_read", 32'(frames_read), 32'd0);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_read_sequencer.md
Name: uart_rx_read_sequencer

Overview:
- Controls the APB read path of the UART RX side. Each APB read of the RX data register causes the block to pop one 12-bit frame from the RX FIFO memory.
- It extracts the data field, checks parity and framing, and returns the byte with a one-cycle PREADY strobe.
- If the FIFO stays empty too long, it returns a timeout response.
- It replaces the ad-hoc shift-register/DFF read chain with a single sequenced controller in the PCLK domain.

Parameters:
- FRAME_W, 12, width of a stored RX frame word.
- DATA_W, 8, maximum data field width and width of PRDATA.
- TIMEOUT_CYCLES, 16, number of WAIT cycles before a timeout response (minimum 2).

Ports:
- PCLK  in  1  system clock.
- PRESET  in  1  synchronous active-high reset.
- rd_req  in  1  APB read access phase (PSEL & PENABLE & ~PWRITE, decoded RX data address).
- number_data_receive  in  4  data bits per frame; valid range 5..8.
- parity_bit_mode  in  1  1 = even parity bit present.
- stop_bit_twice  in  1  1 = two stop bits.
- fifo_not_empty  in  1  RX FIFO holds at least one frame.
- fifo_rd_data  in  FRAME_W  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  single-cycle FIFO pop strobe.
- PREADY  out  1  read response strobe.
- PRDATA  out  DATA_W  extracted data, zero-extended.
- parity_err  out  1  parity mismatch on the returned frame.
- frame_err  out  1  bad start bit or bad stop bit on the returned frame.
- timeout_flag  out  1  response was produced by timeout.
- busy  out  1  FSM is not in IDLE.
- frames_read  out  8  count of frames popped; wraps at 255 -> 0.

Behaviour:
- Reset: a synchronous PRESET at the clock edge forces state IDLE and clears the timeout counter.
  - All outputs and frames_read go to 0 at that edge, including mid-operation.
  - A frame popped before reset is dropped. No pop is issued in the reset cycle.
- FSM has five states: IDLE, WAIT, POP, CAPTURE, RESP.
- IDLE:
  - rd_req=1 and fifo_not_empty=1 -> POP.
  - rd_req=1 and fifo_not_empty=0 -> WAIT, timeout counter cleared.
  - rd_req=0 -> stay in IDLE.
  - rd_req is sampled only in IDLE.
- WAIT:
  - Counter increments every cycle.
  - fifo_not_empty=1 -> POP. This has priority over timeout when both occur in the same cycle.
  - Counter == TIMEOUT_CYCLES-1 with FIFO still empty -> RESP with timeout_flag=1 and PRDATA=0.
- POP: fifo_rd_en=1 for exactly one cycle; frames_read increments; next state CAPTURE.
- CAPTURE: fifo_rd_data is registered into the frame register; next state RESP.
- RESP:
  - PREADY=1 for exactly one cycle; PRDATA and all flags are valid in that cycle; next state IDLE.
  - Outside RESP, PREADY=0 and the flags are 0. PRDATA holds its last value.
- Latency:
  - FIFO non-empty: rd_req in IDLE at cycle 0 -> POP at cycle 1 -> CAPTURE at cycle 2 -> PREADY at cycle 3.
  - Timeout: cycles 1..TIMEOUT_CYCLES are WAIT -> PREADY at cycle TIMEOUT_CYCLES+1.
- Frame layout is LSB first. N is number_data_receive clamped to 5..8 (values <5 act as 5, >8 act as 8). P = parity_bit_mode.
  - bit0: start bit, must be 0.
  - bits N..1: data.
  - bit N+1: parity, present only if P=1.
  - bit N+1+P: stop bit, must be 1.
  - bit N+2+P: second stop bit, present and must be 1 only if stop_bit_twice=1.
  - Higher bits are ignored.
- PRDATA = frame[N:1], zero-extended to DATA_W.
- parity_err = P & (^frame[N:1] ^ frame[N+1]), i.e. even parity is required.
- frame_err = frame[0] | ~stop1 | (stop_bit_twice & ~stop2).
- Config inputs are sampled in CAPTURE/RESP. Changing them mid-read has undefined effect on that one read only.
- Never pops an empty FIFO. Never issues two pops for one request.
- A rd_req still high in the cycle after RESP starts a new read. Per APB this does not occur, because PENABLE drops after PREADY.

Test Plan:
- N=8, P=1, single stop; fifo_rd_data=0x54A, FIFO non-empty.
  - Expected: rd_req at cycle 0 -> fifo_rd_en at cycle 1, PREADY at cycle 3; PRDATA=0xA5, parity_err=0, frame_err=0, frames_read=1.
- N=5, P=0, single stop; frame 0x066.
  - Expected: PRDATA=0x13, no errors.
  - Repeat with 0x067 (start bit=1) -> frame_err=1.
- N=8, P=1; frame 0x74A (parity bit=1 with data 0xA5).
  - Expected: parity_err=1, frame_err=0, PRDATA=0xA5.
- FIFO empty, rd_req held, TIMEOUT_CYCLES=16.
  - Expected: no fifo_rd_en; PREADY at cycle 17 with timeout_flag=1, PRDATA=0.
  - Repeat with fifo_not_empty rising at cycle 16 -> POP at cycle 17, data response at cycle 19, timeout_flag=0.
- Assert PRESET in the CAPTURE cycle.
  - Expected: next cycle IDLE, PREADY=0, frames_read=0, no further fifo_rd_en.
- 256 back-to-back reads with the FIFO always non-empty.
  - Expected: frames_read wraps to 0; exactly one pop per response; PREADY every 4 cycles when rd_req is re-asserted at IDLE.
